// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(16,11) SEC-DED stream decoder: FSM states,
// codeword bit positions and status-byte layout.
package hamming_pkg;

   typedef enum logic [2:0] {
      ST_GET_LSB = 3'd0,
      ST_GET_MSB = 3'd1,
      ST_DECODE  = 3'd2,
      ST_SEND_LO = 3'd3,
      ST_SEND_HI = 3'd4
   } state_t;

   localparam int CODE_W = 16;
   localparam int DATA_W = 11;

   // Parity bit positions; P0 is the overall parity bit.
   localparam int P0 = 0;
   localparam int P1 = 1;
   localparam int P2 = 2;
   localparam int P4 = 4;
   localparam int P8 = 8;

   localparam int SYN_POS [4]         = '{P1, P2, P4, P8};
   localparam int DATA_POS [DATA_W]   = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

   localparam int STAT_DED = 7;
   localparam int STAT_SEC = 6;

   // Positions covered by syndrome bit k: every index i with (i & k) != 0.
   function automatic logic [CODE_W-1:0] syn_mask(input int k);
      logic [CODE_W-1:0] m;
      for (int i = 0; i < CODE_W; i++) begin
         m[i] = ((i & k) != 0);
      end
      return m;
   endfunction

endpackage

// File: rtl/ham16_correct.sv
// Combinational SEC-DED check of one 16-bit codeword: syndrome, classification,
// single-bit correction and data extraction.
import hamming_pkg::*;

module ham16_correct (
   input  logic [CODE_W-1:0] code,
   output logic [DATA_W-1:0] data,
   output logic              sec,
   output logic              ded
);

   logic [3:0]        syn;
   logic              s0;
   logic [CODE_W-1:0] flip;
   logic [CODE_W-1:0] fixed;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_syn
         assign syn[gi] = ^(code & syn_mask(SYN_POS[gi]));
      end
   endgenerate

   assign s0  = ^code;
   assign sec = s0;
   assign ded = ~s0 & (syn != 4'd0);

   // Odd overall parity means one flipped bit at index syn (syn==0 -> p0).
   assign flip  = sec ? (16'd1 << syn) : 16'd0;
   assign fixed = code ^ flip;

   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_data
         assign data[gi] = fixed[DATA_POS[gi]];
      end
   endgenerate

endmodule

// File: rtl/hamming_stream_decoder.sv
// Byte-stream Hamming(16,11) SEC-DED decoder: collects two codeword bytes, decodes,
// emits data-low and status/data-high bytes, and keeps saturating error counters.
import hamming_pkg::*;

module hamming_stream_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_byte,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_byte,
   input  logic             clear_stats,
   output logic [CNT_W-1:0] sec_count,
   output logic [CNT_W-1:0] ded_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            state_reg;
   state_t            state_next;
   logic [7:0]        lsb_reg;
   logic [7:0]        msb_reg;
   logic [7:0]        lo_reg;
   logic [7:0]        hi_reg;
   logic [CNT_W-1:0]  sec_cnt_reg;
   logic [CNT_W-1:0]  ded_cnt_reg;
   logic              in_xfer;
   logic              out_xfer;
   logic [DATA_W-1:0] dec_data;
   logic              dec_sec;
   logic              dec_ded;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   ham16_correct u_correct (
      .code (({msb_reg, lsb_reg})),
      .data (dec_data),
      .sec  (dec_sec),
      .ded  (dec_ded)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_GET_LSB;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_GET_LSB: if (in_xfer)  state_next = ST_GET_MSB;
         ST_GET_MSB: if (in_xfer)  state_next = ST_DECODE;
         ST_DECODE:                state_next = ST_SEND_LO;
         ST_SEND_LO: if (out_xfer) state_next = ST_SEND_HI;
         ST_SEND_HI: if (out_xfer) state_next = ST_GET_LSB;
         default:                  state_next = ST_GET_LSB;
      endcase
   end

   // in_ready is gated by reset_n so it reads 0 throughout reset.
   always_comb begin
      in_ready  = reset_n & ((state_reg == ST_GET_LSB) | (state_reg == ST_GET_MSB));
      out_valid = (state_reg == ST_SEND_LO) | (state_reg == ST_SEND_HI);
      out_byte  = (state_reg == ST_SEND_HI) ? hi_reg : lo_reg;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lsb_reg <= 8'h00;
         msb_reg <= 8'h00;
         lo_reg  <= 8'h00;
         hi_reg  <= 8'h00;
      end else begin
         if (in_xfer && state_reg == ST_GET_LSB) lsb_reg <= in_byte;
         if (in_xfer && state_reg == ST_GET_MSB) msb_reg <= in_byte;
         if (state_reg == ST_DECODE) begin
            lo_reg           <= dec_data[7:0];
            hi_reg           <= {5'b00000, dec_data[10:8]};
            hi_reg[STAT_DED] <= dec_ded;
            hi_reg[STAT_SEC] <= dec_sec;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sec_cnt_reg <= '0;
         ded_cnt_reg <= '0;
      end else if (clear_stats) begin
         sec_cnt_reg <= '0;
         ded_cnt_reg <= '0;
      end else if (state_reg == ST_DECODE) begin
         if (dec_sec && sec_cnt_reg != CNT_MAX) sec_cnt_reg <= sec_cnt_reg + CNT_ONE;
         if (dec_ded && ded_cnt_reg != CNT_MAX) ded_cnt_reg <= ded_cnt_reg + CNT_ONE;
      end
   end

   assign sec_count = sec_cnt_reg;
   assign ded_count = ded_cnt_reg;

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Self-checking bench for hamming_stream_decoder: directed cases plus random
// codewords built by an encoder model with 0, 1 or 2 injected bit errors.
module tb_hamming_stream_decoder;

   localparam int CNT_W = 8;
   localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_byte;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_byte;
   logic             clear_stats;
   logic [CNT_W-1:0] sec_count;
   logic [CNT_W-1:0] ded_count;

   int n_checks = 0;
   int n_errors = 0;
   int sec_exp  = 0;
   int ded_exp  = 0;

   hamming_stream_decoder #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_byte     (in_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_byte    (out_byte),
      .clear_stats (clear_stats),
      .sec_count   (sec_count),
      .ded_count   (ded_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Encoder: place data, then choose p1..p8 so the XOR of set-bit indices is 0,
   // then p0 so the total parity is even.
   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] c;
      logic [3:0]  x;
      c = '0;
      for (int k = 0; k < 11; k++) c[DPOS[k]] = d[k];
      x = '0;
      for (int i = 1; i < 16; i++) if (c[i]) x = x ^ 4'(i);
      c[1] = x[0];
      c[2] = x[1];
      c[4] = x[2];
      c[8] = x[3];
      c[0] = ^c[15:1];
      return c;
   endfunction

   function automatic logic [10:0] raw_data(input logic [15:0] c);
      logic [10:0] d;
      for (int k = 0; k < 11; k++) d[k] = c[DPOS[k]];
      return d;
   endfunction

   task automatic put_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_byte  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic get_byte(output logic [7:0] b);
      int n;
      n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("out_valid_timeout", 32'(out_valid), 32'd1);
      b = out_byte;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic do_word(input string tag, input logic [7:0] lsb, input logic [7:0] msb,
                          input logic [7:0] exp_lo, input logic [7:0] exp_hi);
      logic [7:0] lo;
      logic [7:0] hi;
      put_byte(lsb);
      put_byte(msb);
      get_byte(lo);
      get_byte(hi);
      $display("word %s in=%02h,%02h out=%02h,%02h sec=%0d ded=%0d",
               tag, lsb, msb, lo, hi, sec_count, ded_count);
      check({tag, "_lo"}, 32'(lo), 32'(exp_lo));
      check({tag, "_hi"}, 32'(hi), 32'(exp_hi));
      check({tag, "_sec"}, 32'(sec_count), 32'(sec_exp));
      check({tag, "_ded"}, 32'(ded_count), 32'(ded_exp));
   endtask

   // Random word with nerr distinct flipped bits; expectations from the encoder model.
   task automatic rand_word(input int nerr, input bit verbose);
      logic [10:0] d;
      logic [15:0] c;
      logic [10:0] r;
      logic [7:0]  lo;
      logic [7:0]  hi;
      int          a;
      int          b;
      d = 11'($urandom);
      c = encode(d);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      if (nerr >= 1) c[a] = ~c[a];
      if (nerr >= 2) c[b] = ~c[b];
      if (nerr == 2) begin
         r  = raw_data(c);
         lo = r[7:0];
         hi = {5'b10000, r[10:8]};
         if (ded_exp < 255) ded_exp++;
      end else begin
         lo = d[7:0];
         hi = {(nerr == 1) ? 5'b01000 : 5'b00000, d[10:8]};
         if (nerr == 1 && sec_exp < 255) sec_exp++;
      end
      if (verbose) begin
         do_word("rand", c[7:0], c[15:8], lo, hi);
      end else begin
         put_byte(c[7:0]);
         put_byte(c[15:8]);
         get_byte(lo);
         get_byte(hi);
      end
   endtask

   initial begin
      logic [7:0] b;
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_byte     = 8'h00;
      out_ready   = 1'b0;
      clear_stats = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_byte", 32'(out_byte), 32'h00);
      check("rst_sec", 32'(sec_count), 32'd0);
      check("rst_ded", 32'(ded_count), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      do_word("clean_001", 8'h0F, 8'h00, 8'h01, 8'h00);
      do_word("clean_7ff", 8'hFF, 8'hFF, 8'hFF, 8'h07);
      sec_exp = 1;
      do_word("sec_c5", 8'h2F, 8'h00, 8'h01, 8'h40);
      sec_exp = 2;
      do_word("sec_p0", 8'h0E, 8'h00, 8'h01, 8'h40);
      ded_exp = 1;
      do_word("ded_c0c1", 8'h0C, 8'h00, 8'h01, 8'h80);

      // Latency and backpressure on byte 0.
      put_byte(8'hFF);
      put_byte(8'hFF);
      check("lat_decode_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_send_valid", 32'(out_valid), 32'd1);
      check("lat_send_byte", 32'(out_byte), 32'hFF);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("stall_byte", 32'(out_byte), 32'hFF);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hi_no_bubble_valid", 32'(out_valid), 32'd1);
      check("hi_no_bubble_byte", 32'(out_byte), 32'h07);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("in_ready_after_hi", 32'(in_ready), 32'd1);
      check("out_valid_after_hi", 32'(out_valid), 32'd0);
      $display("stall sequence done in_ready=%0d", in_ready);

      for (int i = 0; i < 40; i++) rand_word($urandom_range(0, 2), 1'b1);

      for (int i = 0; i < 300; i++) rand_word(1, 1'b0);
      $display("saturation run sec=%0d ded=%0d", sec_count, ded_count);
      check("sec_saturated", 32'(sec_count), 32'd255);
      check("ded_after_sat", 32'(ded_count), 32'(ded_exp));

      // clear_stats coinciding with a SEC decode cycle.
      put_byte(8'h2F);
      put_byte(8'h00);
      clear_stats = 1'b1;
      @(posedge clk);
      #1;
      clear_stats = 1'b0;
      sec_exp = 0;
      ded_exp = 0;
      check("clear_sec", 32'(sec_count), 32'd0);
      check("clear_ded", 32'(ded_count), 32'd0);
      get_byte(b);
      check("clear_word_lo", 32'(b), 32'h01);
      get_byte(b);
      check("clear_word_hi", 32'(b), 32'h40);
      check("clear_sec_after", 32'(sec_count), 32'd0);
      $display("clear on decode sec=%0d", sec_count);

      // Reset after the LSB transfer discards the partial word.
      sec_exp = 1;
      do_word("pre_reset", 8'h2F, 8'h00, 8'h01, 8'h40);
      put_byte(8'h55);
      reset_n = 1'b0;
      #1;
      sec_exp = 0;
      ded_exp = 0;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_byte", 32'(out_byte), 32'h00);
      check("midrst_sec", 32'(sec_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("midrst_release_ready", 32'(in_ready), 32'd1);
      do_word("fresh_after_rst", 8'h0F, 8'h00, 8'h01, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
